// File: rtl/product_accumulator.sv
// Sums the 16 ternary lanes of each product word, accumulates WORDS_PER_SYMBOL words
// into one signed correlation value and emits it with a hard decision and erasure flag.
module product_accumulator #(
    parameter int WORDS_PER_SYMBOL = 4,
    parameter int ACC_W            = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_bit,
    output logic             out_erasure
);

    localparam int CNT_W = (WORDS_PER_SYMBOL > 1) ? $clog2(WORDS_PER_SYMBOL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_SYMBOL - 1);

    logic [15:0]             lane_pos;
    logic [15:0]             lane_neg;
    logic [4:0]              pos_cnt;
    logic [4:0]              neg_cnt;
    logic signed [5:0]       wsum;
    logic                    stall;
    logic                    accept;
    logic                    last_word;
    logic signed [ACC_W-1:0] wsum_ext;
    logic signed [ACC_W-1:0] acc_next;

    logic                    s1_valid_reg;
    logic signed [5:0]       s1_wsum_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    out_valid_reg;
    logic [ACC_W-1:0]        out_sum_reg;
    logic                    out_bit_reg;
    logic                    out_erasure_reg;

    // Lane code 10 decodes as neither positive nor negative, i.e. zero.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign lane_pos[gi] = prod[2*gi] & ~prod[2*gi+1];
            assign lane_neg[gi] = prod[2*gi] &  prod[2*gi+1];
        end
    endgenerate

    always_comb begin
        pos_cnt = '0;
        neg_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            pos_cnt = pos_cnt + {4'd0, lane_pos[i]};
            neg_cnt = neg_cnt + {4'd0, lane_neg[i]};
        end
        wsum = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    end

    assign stall     = out_valid_reg & ~out_ready;
    assign in_ready  = rst_n & ~stall;
    assign accept    = in_valid & in_ready;
    assign last_word = (cnt_reg == CNT_LAST);
    assign wsum_ext  = ACC_W'(s1_wsum_reg);
    // The first word of a symbol restarts the sum instead of adding to the stale one.
    assign acc_next  = (cnt_reg == '0) ? wsum_ext : acc_reg + wsum_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg    <= 1'b0;
            s1_wsum_reg     <= '0;
            cnt_reg         <= '0;
            acc_reg         <= '0;
            out_valid_reg   <= 1'b0;
            out_sum_reg     <= '0;
            out_bit_reg     <= 1'b0;
            out_erasure_reg <= 1'b0;
        end else if (!stall) begin
            s1_valid_reg <= accept;
            s1_wsum_reg  <= wsum;
            if (s1_valid_reg) begin
                acc_reg <= acc_next;
                cnt_reg <= last_word ? '0 : cnt_reg + CNT_W'(1);
            end
            // Not stalled implies any held result is being consumed this edge.
            if (s1_valid_reg && last_word) begin
                out_valid_reg   <= 1'b1;
                out_sum_reg     <= acc_next;
                out_bit_reg     <= acc_next[ACC_W-1];
                out_erasure_reg <= (acc_next == '0);
            end else begin
                out_valid_reg   <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_sum     = out_sum_reg;
    assign out_bit     = out_bit_reg;
    assign out_erasure = out_erasure_reg;

endmodule
